congestion_monitor: RTL and testbench
=====================================

Name: congestion_monitor

Overview:
- Roadside sensing block that produces the `congestion` input consumed by the junction traffic-light controller.
- Counts vehicles queued on the main road from arrival and departure loop sensors, using the controller's 2-bit light-state code to qualify departures.
- Asserts `congestion` with hysteresis, and forces a cool-down so the side road is never starved.

Parameters:
- CNT_W, 5, width of the queue counter (max count 2^CNT_W-1).
- HIGH_TH, 10, queue count at or above which congestion is raised.
- LOW_TH, 4, queue count at or below which congestion is cleared; must satisfy LOW_TH < HIGH_TH <= 2^CNT_W-1.
- MAX_HOLD, 64, number of consecutive main-GO cycles allowed under congestion before a forced cool-down.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- road_state  input  2  light-state code from the controller: 0=main GO, 1=main GO-ATTENTION, 2=main STOP/side GO, 3=main STOP-ATTENTION.
- arrive_sense  input  1  main-road arrival loop sensor (level; each rising edge is one vehicle).
- depart_sense  input  1  main-road stop-line departure sensor (level; each rising edge is one vehicle).
- congestion  output  1  registered; high while in CONGESTED state.
- queue_count  output  CNT_W  registered current queue estimate.
- overflow  output  1  sticky; set when an arrival is lost at counter saturation.
- starve_guard  output  1  registered; high while in COOLDOWN.
- violation  output  1  one-cycle pulse; departure seen while road_state is 2 or 3.

Behaviour:
- Reset (synchronous, active-high): next rising edge clears queue_count, overflow, congestion, starve_guard, violation, hold counter and sensor delay registers, and sets FSM to CLEAR. Reset mid-operation aborts any state identically.
- A sensor held high across reset release counts as one event.
- Sensor edge detection: d1 <= sense, d2 <= d1; evt = d1 & ~d2.
  - A sensor rising before edge N updates queue_count at edge N+1 (2-cycle latency).
  - A held-high sensor counts once.
- Departures are accepted only when road_state is 0 or 1.
  - A departure event with road_state 2 or 3 is ignored by the counter.
  - It pulses violation high for exactly one cycle, at the same edge the count would have changed.
- Counter update per cycle:
  - arrival only: +1.
  - accepted departure only: -1.
  - both at once: unchanged.
  - neither: unchanged.
- Saturation:
  - Arrival at 2^CNT_W-1 keeps the count at max and sets overflow, which stays set until reset.
  - A simultaneous accepted departure at max still leaves the count unchanged and does not set overflow.
  - Departure at 0 stays at 0 with no flag.
- FSM evaluates the registered queue_count (pre-update value); outputs are decoded from the registered state.
  - CLEAR: congestion=0, starve_guard=0. Go to CONGESTED when queue_count >= HIGH_TH. On entry to CONGESTED, hold counter := 0.
  - CONGESTED: congestion=1. Hold counter increments each cycle road_state==0 and holds otherwise.
    - If queue_count <= LOW_TH, go to CLEAR. This has priority over the timeout.
    - Else if hold counter == MAX_HOLD-1 and road_state==0, go to COOLDOWN.
  - COOLDOWN: congestion=0, starve_guard=1, counter still tracks traffic. When road_state==2 is sampled, go to CLEAR.
- Congestion rises one edge after queue_count first shows >= HIGH_TH, and falls one edge after queue_count shows <= LOW_TH.
- road_state value 3 is never a departure window; all 2-bit codes are legal, with no default trap.

Test Plan:
- Reset, road_state=2, 10 arrival pulses (2 high/2 low cycles each) -> queue_count steps 1..10, congestion rises one cycle after count==10; violation and overflow stay 0.
- From count 10 congested, road_state=0, departure pulses -> congestion stays 1 at counts 9..5 and drops to 0 one cycle after count==4.
- road_state=2, one depart_sense pulse at count 7 -> count stays 7, violation high exactly 1 cycle.
- 33 arrival pulses from 0 -> count saturates at 31, overflow=1 from the 32nd arrival and remains 1 until reset.
- Count 12, congested, road_state held 0 for 64 cycles with no departures -> congestion 0 and starve_guard 1 after cycle 64. Then road_state=2 -> CLEAR next edge and congestion 1 on the following edge (count still 12).
- road_state=1, simultaneous arrival and departure edges at count 6 -> count stays 6. Assert reset for 1 cycle while congested -> all outputs 0 and FSM CLEAR at that edge.

Source files
------------

// File: rtl/congestion_monitor.sv
// Main-road queue estimator feeding the junction controller's congestion input.
// Counts loop-sensor edges, raises congestion with hysteresis, and forces a cool-down after a long main GO.
module congestion_monitor #(
  parameter int CNT_W    = 5,
  parameter int HIGH_TH  = 10,
  parameter int LOW_TH   = 4,
  parameter int MAX_HOLD = 64
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [1:0]       road_state_i,
  input  logic             arrive_sense_i,
  input  logic             depart_sense_i,
  output logic             congestion_o,
  output logic [CNT_W-1:0] queue_count_o,
  output logic             overflow_o,
  output logic             starve_guard_o,
  output logic             violation_o
);

  // state | meaning
  // CLEAR     | queue below raise threshold, no congestion reported
  // CONGESTED | congestion reported, main-GO hold time being measured
  // COOLDOWN  | congestion masked until the side road has been given GO
  typedef enum logic [1:0] {
    ST_CLEAR     = 2'd0,
    ST_CONGESTED = 2'd1,
    ST_COOLDOWN  = 2'd2
  } state_e;

  localparam int               HOLD_W  = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HIGH_C  = CNT_W'(HIGH_TH);
  localparam logic [CNT_W-1:0] LOW_C   = CNT_W'(LOW_TH);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  localparam logic [1:0] RS_MAIN_GO  = 2'd0;
  localparam logic [1:0] RS_SIDE_GO  = 2'd2;

  logic              arr_d1_q, arr_d2_q;
  logic              dep_d1_q, dep_d2_q;
  logic              arr_evt, dep_evt, dep_ok, main_open;

  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              viol_q, viol_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  state_e            state_q, state_d;

  // Sensor synchronisation and rising-edge extraction
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      arr_d1_q <= 1'b0;
      arr_d2_q <= 1'b0;
      dep_d1_q <= 1'b0;
      dep_d2_q <= 1'b0;
    end else begin
      arr_d1_q <= arrive_sense_i;
      arr_d2_q <= arr_d1_q;
      dep_d1_q <= depart_sense_i;
      dep_d2_q <= dep_d1_q;
    end
  end

  assign arr_evt   = arr_d1_q & ~arr_d2_q;
  assign dep_evt   = dep_d1_q & ~dep_d2_q;
  // Codes 0 and 1 both have main-road traffic moving past the stop line
  assign main_open = ~road_state_i[1];
  assign dep_ok    = dep_evt & main_open;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    unique case ({arr_evt, dep_ok})
      2'b10: begin
        if (count_q == CNT_MAX) begin
          ovf_d = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      2'b01: begin
        if (count_q != '0) begin
          count_d = count_q - CNT_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  assign viol_d = dep_evt & ~main_open;

  // Hold time is only meaningful inside CONGESTED; zeroing elsewhere gives a clean start on entry
  always_comb begin
    hold_d = hold_q;
    if (state_q != ST_CONGESTED) begin
      hold_d = '0;
    end else if (road_state_i == RS_MAIN_GO) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      viol_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      viol_q  <= viol_d;
      hold_q  <= hold_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // Decisions use the registered count, so hysteresis lags the counter by one edge
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CLEAR: begin
        if (count_q >= HIGH_C) begin
          state_d = ST_CONGESTED;
        end
      end
      ST_CONGESTED: begin
        if (count_q <= LOW_C) begin
          state_d = ST_CLEAR;
        end else if ((hold_q == HOLD_LAST) && (road_state_i == RS_MAIN_GO)) begin
          state_d = ST_COOLDOWN;
        end
      end
      ST_COOLDOWN: begin
        if (road_state_i == RS_SIDE_GO) begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_comb begin
    congestion_o   = 1'b0;
    starve_guard_o = 1'b0;
    unique case (state_q)
      ST_CONGESTED: congestion_o   = 1'b1;
      ST_COOLDOWN:  starve_guard_o = 1'b1;
      default: begin
      end
    endcase
  end

  assign queue_count_o = count_q;
  assign overflow_o    = ovf_q;
  assign violation_o   = viol_q;

endmodule

// File: tb/tb_congestion_monitor.sv
// Directed bench for congestion_monitor: expected output snapshots are queued with each
// stimulus step and popped/compared once the DUT has had time to respond.
module tb_congestion_monitor;

  localparam int CNT_W    = 5;
  localparam int HIGH_TH  = 10;
  localparam int LOW_TH   = 4;
  localparam int MAX_HOLD = 64;
  localparam int CNT_MAX  = 31;

  logic             clock = 1'b0;
  logic             reset;
  logic [1:0]       road_state;
  logic             arrive_sense;
  logic             depart_sense;
  logic             congestion;
  logic [CNT_W-1:0] queue_count;
  logic             overflow;
  logic             starve_guard;
  logic             violation;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [4:0] cnt;
    logic       cong;
    logic       sg;
    logic       ovf;
    logic       viol;
  } exp_t;

  exp_t sb[$];

  congestion_monitor #(
    .CNT_W(CNT_W), .HIGH_TH(HIGH_TH), .LOW_TH(LOW_TH), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clock_i        (clock),
    .reset_i        (reset),
    .road_state_i   (road_state),
    .arrive_sense_i (arrive_sense),
    .depart_sense_i (depart_sense),
    .congestion_o   (congestion),
    .queue_count_o  (queue_count),
    .overflow_o     (overflow),
    .starve_guard_o (starve_guard),
    .violation_o    (violation)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input string tag, input int cnt, input bit cong, input bit sg,
                      input bit ovf, input bit viol);
    exp_t e;
    e.tag  = tag;
    e.cnt  = 5'(cnt);
    e.cong = cong;
    e.sg   = sg;
    e.ovf  = ovf;
    e.viol = viol;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t       e;
    logic [8:0] obs;
    logic [8:0] expv;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_underflow observed=no_entry expected=entry");
    end
    if (sb.size() == 0) return;
    e    = sb.pop_front();
    obs  = {queue_count, congestion, starve_guard, overflow, violation};
    expv = {e.cnt, e.cong, e.sg, e.ovf, e.viol};
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed cnt=%0d cong=%b sg=%b ovf=%b viol=%b expected cnt=%0d cong=%b sg=%b ovf=%b viol=%b",
             e.tag, queue_count, congestion, starve_guard, overflow, violation,
             e.cnt, e.cong, e.sg, e.ovf, e.viol);
    end
  endtask

  // Two cycles high, two low; snapshots taken after the count edge and one edge later
  task automatic pulse(input bit a, input bit d);
    arrive_sense = a;
    depart_sense = d;
    tick();
    tick();
    check_out();
    arrive_sense = 1'b0;
    depart_sense = 1'b0;
    tick();
    check_out();
    tick();
  endtask

  initial begin
    int c;
    int cp;
    reset        = 1'b1;
    road_state   = 2'd2;
    arrive_sense = 1'b0;
    depart_sense = 1'b0;
    tick();
    tick();
    push("reset_init", 0, 0, 0, 0, 0);
    check_out();

    // Arrival sensor already high when reset releases: exactly one vehicle
    arrive_sense = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    push("held_across_reset", 1, 0, 0, 0, 0);
    check_out();
    tick();
    tick();
    push("held_counts_once", 1, 0, 0, 0, 0);
    check_out();
    arrive_sense = 1'b0;
    tick();
    tick();

    // Departures to and below empty
    road_state = 2'd0;
    push("dep_to_zero_e2", 0, 0, 0, 0, 0);
    push("dep_to_zero_e3", 0, 0, 0, 0, 0);
    pulse(1'b0, 1'b1);
    push("dep_at_zero_e2", 0, 0, 0, 0, 0);
    push("dep_at_zero_e3", 0, 0, 0, 0, 0);
    pulse(1'b0, 1'b1);

    // Build up to the raise threshold with side road on GO
    road_state = 2'd2;
    for (int i = 1; i <= 10; i++) begin
      push("arr_rise_e2", i, 0, 0, 0, 0);
      push("arr_rise_e3", i, (i >= HIGH_TH), 0, 0, 0);
      pulse(1'b1, 1'b0);
    end

    // Drain on main GO: congestion holds until the count reaches LOW_TH
    road_state = 2'd0;
    for (int k = 9; k >= 4; k--) begin
      push("drain_e2", k, 1, 0, 0, 0);
      push("drain_e3", k, (k > LOW_TH), 0, 0, 0);
      pulse(1'b0, 1'b1);
    end

    // Up to 7, then a departure while main is stopped
    road_state = 2'd2;
    for (int k = 5; k <= 7; k++) begin
      push("arr_to7_e2", k, 0, 0, 0, 0);
      push("arr_to7_e3", k, 0, 0, 0, 0);
      pulse(1'b1, 1'b0);
    end
    push("violation_e2", 7, 0, 0, 0, 1);
    push("violation_e3", 7, 0, 0, 0, 0);
    pulse(1'b0, 1'b1);
    road_state = 2'd3;
    push("violation_rs3_e2", 7, 0, 0, 0, 1);
    push("violation_rs3_e3", 7, 0, 0, 0, 0);
    pulse(1'b0, 1'b1);

    // Simultaneous arrival and departure on GO-ATTENTION
    road_state = 2'd0;
    push("dep_to6_e2", 6, 0, 0, 0, 0);
    push("dep_to6_e3", 6, 0, 0, 0, 0);
    pulse(1'b0, 1'b1);
    road_state = 2'd1;
    push("simul_e2", 6, 0, 0, 0, 0);
    push("simul_e3", 6, 0, 0, 0, 0);
    pulse(1'b1, 1'b1);

    // Up to 12 congested, then a long main GO forces cool-down
    road_state = 2'd2;
    for (int k = 7; k <= 12; k++) begin
      push("arr_to12_e2", k, (k - 1 >= HIGH_TH), 0, 0, 0);
      push("arr_to12_e3", k, (k >= HIGH_TH), 0, 0, 0);
      pulse(1'b1, 1'b0);
    end
    road_state = 2'd0;
    for (int k = 1; k < MAX_HOLD; k++) tick();
    push("hold_before_timeout", 12, 1, 0, 0, 0);
    check_out();
    tick();
    push("timeout_cooldown", 12, 0, 1, 0, 0);
    check_out();
    road_state = 2'd1;
    tick();
    push("cooldown_rs1", 12, 0, 1, 0, 0);
    check_out();
    road_state = 2'd2;
    tick();
    push("cooldown_exit", 12, 0, 0, 0, 0);
    check_out();
    tick();
    push("recongest", 12, 1, 0, 0, 0);
    check_out();

    // Reset mid-operation while congested
    reset = 1'b1;
    tick();
    push("reset_mid", 0, 0, 0, 0, 0);
    check_out();
    reset = 1'b0;

    // Saturation and sticky overflow
    road_state = 2'd2;
    for (int i = 1; i <= 33; i++) begin
      c  = (i > CNT_MAX) ? CNT_MAX : i;
      cp = (i - 1 > CNT_MAX) ? CNT_MAX : i - 1;
      push("sat_e2", c, (cp >= HIGH_TH), 0, (i > CNT_MAX), 0);
      push("sat_e3", c, (c >= HIGH_TH), 0, (i > CNT_MAX), 0);
      pulse(1'b1, 1'b0);
      if (i == CNT_MAX) begin
        road_state = 2'd0;
        push("simul_at_max_e2", CNT_MAX, 1, 0, 0, 0);
        push("simul_at_max_e3", CNT_MAX, 1, 0, 0, 0);
        pulse(1'b1, 1'b1);
        road_state = 2'd2;
      end
    end
    road_state = 2'd0;
    push("ovf_sticky_e2", 30, 1, 0, 1, 0);
    push("ovf_sticky_e3", 30, 1, 0, 1, 0);
    pulse(1'b0, 1'b1);

    reset = 1'b1;
    tick();
    push("reset_clears_ovf", 0, 0, 0, 0, 0);
    check_out();
    reset = 1'b0;
    tick();
    push("post_reset_idle", 0, 0, 0, 0, 0);
    check_out();

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
